// File: rtl/exp_align_pipe_if.sv
// Operand/result bundle for exp_align_pipe.
// Purpose: groups the input valid/ready handshake with the operand pair, and the output
//          valid/ready handshake with the aligned result.
// Modports:
//   slave  - the aligner: takes operands and out_ready, drives in_ready and the result.
//   master - the surrounding datapath: drives operands and out_ready, takes the result.
// Parameters: EXP_W exponent width, MAN_W mantissa width including the hidden bit.
interface exp_align_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_big;
  logic [MAN_W+1:0] man_big;
  logic [MAN_W+1:0] man_small;
  logic             sticky;
  logic             swapped;
  logic [EXP_W-1:0] exp_diff;

  modport slave (
    input  in_valid, exp_a, exp_b, man_a, man_b, out_ready,
    output in_ready, out_valid, exp_big, man_big, man_small, sticky, swapped, exp_diff
  );

  modport master (
    output in_valid, exp_a, exp_b, man_a, man_b, out_ready,
    input  in_ready, out_valid, exp_big, man_big, man_small, sticky, swapped, exp_diff
  );
endinterface

// File: rtl/exp_align_pipe.sv
// Exponent comparator and mantissa aligner for the FPU add/subtract path.
// Purpose: stage 1 compares exponents and orders the operands (larger exponent first);
//          stage 2 right-shifts the smaller mantissa (with two guard/round bits appended)
//          by the exponent difference and collects the shifted-out bits into sticky.
//          Two-stage valid/ready pipeline, full throughput, backpressure via out_ready.
// Ports:
//   CLK - clock, all state on the rising edge
//   RST - synchronous active-high reset; clears valids and all data registers
//   bus - exp_align_pipe_if.slave: in_valid/in_ready + exp_a/exp_b/man_a/man_b in;
//         out_valid/out_ready + exp_big/man_big/man_small/sticky/swapped/exp_diff out
module exp_align_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
) (
  input logic             CLK,
  input logic             RST,
  exp_align_pipe_if.slave bus
);
  localparam int unsigned ShW = MAN_W + 2;

  // Stage 1 state
  logic             s1_v_q;
  logic [EXP_W-1:0] s1_exp_big_q;
  logic [MAN_W-1:0] s1_big_q;
  logic [MAN_W-1:0] s1_small_q;
  logic             s1_swapped_q;
  logic [EXP_W-1:0] s1_diff_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_v_q;
  logic [EXP_W-1:0] exp_big_q;
  logic [ShW-1:0]   man_big_q;
  logic [ShW-1:0]   man_small_q;
  logic             sticky_q;
  logic             swapped_q;
  logic [EXP_W-1:0] exp_diff_q;

  logic s1_adv;
  logic s2_adv;

  // Ready ripples back combinationally from out_ready; no skid buffer.
  always_comb begin
    s2_adv = !s2_v_q || bus.out_ready;
    s1_adv = !s1_v_q || s2_adv;
  end

  // Stage 1 compare
  logic [EXP_W:0]   d_c;
  logic             swap_c;
  logic [EXP_W-1:0] diff_c;

  always_comb begin
    d_c    = {1'b0, bus.exp_a} - {1'b0, bus.exp_b};
    swap_c = d_c[EXP_W];
    // Two's-complement negate gives the true magnitude when exp_a < exp_b.
    diff_c = swap_c ? (-d_c[EXP_W-1:0]) : d_c[EXP_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q       <= 1'b0;
      s1_exp_big_q <= '0;
      s1_big_q     <= '0;
      s1_small_q   <= '0;
      s1_swapped_q <= 1'b0;
      s1_diff_q    <= '0;
    end else if (s1_adv) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_swapped_q <= swap_c;
        s1_diff_q    <= diff_c;
        s1_exp_big_q <= swap_c ? bus.exp_b : bus.exp_a;
        s1_big_q     <= swap_c ? bus.man_b : bus.man_a;
        s1_small_q   <= swap_c ? bus.man_a : bus.man_b;
      end
    end
  end

  // Stage 2 align. The small mantissa is placed in the upper half of a double-width word so
  // the bits shifted past bit 0 land in the lower half and can be OR-reduced for sticky.
  logic [2*ShW-1:0] wide_c;
  logic [ShW-1:0]   shifted_c;
  logic             sticky_c;

  always_comb begin
    wide_c    = {s1_small_q, 2'b00, {ShW{1'b0}}} >> s1_diff_q;
    shifted_c = wide_c[2*ShW-1:ShW];
    sticky_c  = |wide_c[ShW-1:0];
    if (32'(s1_diff_q) >= ShW) begin
      shifted_c = '0;
      sticky_c  = |s1_small_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_v_q      <= 1'b0;
      exp_big_q   <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      exp_diff_q  <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        exp_big_q   <= s1_exp_big_q;
        man_big_q   <= {s1_big_q, 2'b00};
        man_small_q <= shifted_c;
        sticky_q    <= sticky_c;
        swapped_q   <= s1_swapped_q;
        exp_diff_q  <= s1_diff_q;
      end
    end
  end

  always_comb begin
    bus.in_ready  = s1_adv;
    bus.out_valid = s2_v_q;
    bus.exp_big   = exp_big_q;
    bus.man_big   = man_big_q;
    bus.man_small = man_small_q;
    bus.sticky    = sticky_q;
    bus.swapped   = swapped_q;
    bus.exp_diff  = exp_diff_q;
  end
endmodule

// File: tb/tb_exp_align_pipe.sv
// Self-checking bench for exp_align_pipe (EXP_W=8, MAN_W=24).
// Hand-computed vector table plus random streaming checked through an expected-result
// queue; hand-written sequences cover backpressure and reset with both stages full.
module tb_exp_align_pipe;
  typedef struct packed {
    logic [7:0]  exp_big;
    logic [25:0] man_big;
    logic [25:0] man_small;
    logic        sticky;
    logic        swapped;
    logic [7:0]  exp_diff;
  } res_t;

  typedef struct packed {
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    res_t        res;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  res_t q[$];

  bit stream_mode = 1'b0;
  int stream_cnt = 0;
  int stream_first = 0;
  int stream_last = 0;

  exp_align_pipe_if #(.EXP_W(8), .MAN_W(24)) bus ();

  exp_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic res_t actual();
    return {bus.exp_big, bus.man_big, bus.man_small, bus.sticky, bus.swapped, bus.exp_diff};
  endfunction

  // Bit-by-bit reference: each bit of {small,00} either moves down by diff or feeds sticky.
  function automatic res_t model(logic [7:0] ea, logic [7:0] eb, logic [23:0] ma,
                                 logic [23:0] mb);
    res_t        r;
    logic [25:0] s;
    int          diff;
    r = '0;
    if (ea < eb) begin
      r.swapped = 1'b1;
      r.exp_big = eb;
      diff      = int'(eb) - int'(ea);
      r.man_big = {mb, 2'b00};
      s         = {ma, 2'b00};
    end else begin
      r.exp_big = ea;
      diff      = int'(ea) - int'(eb);
      r.man_big = {ma, 2'b00};
      s         = {mb, 2'b00};
    end
    r.exp_diff = 8'(diff);
    for (int i = 0; i < 26; i++) begin
      if (s[i]) begin
        if (i >= diff) r.man_small[i-diff] = 1'b1;
        else r.sticky = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got exp_big=%h man_big=%h man_small=%h sticky=%b swapped=%b diff=%h, required exp_big=%h man_big=%h man_small=%h sticky=%b swapped=%b diff=%h",
               name, act.exp_big, act.man_big, act.man_small, act.sticky, act.swapped,
               act.exp_diff, exp.exp_big, exp.man_big, exp.man_small, exp.sticky,
               exp.swapped, exp.exp_diff);
    end
  endtask

  // Output monitor: a transfer happens at the coming edge when both are high mid-cycle.
  always @(negedge CLK) begin
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(bus.out_valid), 64'd0);
      end else begin
        chk_res("result", actual(), q.pop_front());
      end
      if (stream_mode) begin
        if (stream_cnt == 0) stream_first = cyc;
        stream_last = cyc;
        stream_cnt++;
      end
    end
  end

  // Offer one operand pair; called just after a rising edge, returns just after the edge
  // at which it was accepted.
  task automatic send(input vec_t v);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.exp_a    = v.ea;
    bus.exp_b    = v.eb;
    bus.man_a    = v.ma;
    bus.man_b    = v.mb;
    forever begin
      @(negedge CLK);
      if (bus.in_ready) begin
        q.push_back(v.res);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(logic [7:0] ea, logic [7:0] eb, logic [23:0] ma, logic [23:0] mb);
    vec_t v;
    v.ea  = ea;
    v.eb  = eb;
    v.ma  = ma;
    v.mb  = mb;
    v.res = model(ea, eb, ma, mb);
    return v;
  endfunction

  initial begin
    vec_t tbl[10];
    vec_t va, vb, vc;
    res_t zero_res;
    zero_res = '0;

    // {ea, eb, ma, mb, {exp_big, man_big, man_small, sticky, swapped, exp_diff}}
    tbl[0] = '{8'h85, 8'h80, 24'h800000, 24'hC00000, '{8'h85, 26'h2000000, 26'h0180000, 1'b0, 1'b0, 8'h05}};
    tbl[1] = '{8'h10, 8'h40, 24'h000001, 24'h800000, '{8'h40, 26'h2000000, 26'h0000000, 1'b1, 1'b1, 8'h30}};
    tbl[2] = '{8'h10, 8'h40, 24'h000000, 24'h800000, '{8'h40, 26'h2000000, 26'h0000000, 1'b0, 1'b1, 8'h30}};
    tbl[3] = '{8'hFF, 8'h00, 24'hABCDEF, 24'h800000, '{8'hFF, 26'h2AF37BC, 26'h0000000, 1'b1, 1'b0, 8'hFF}};
    tbl[4] = '{8'h00, 8'hFF, 24'h800000, 24'hC00000, '{8'hFF, 26'h3000000, 26'h0000000, 1'b1, 1'b1, 8'hFF}};
    tbl[5] = '{8'h7F, 8'h7F, 24'h900000, 24'hA5A5A5, '{8'h7F, 26'h2400000, 26'h2969694, 1'b0, 1'b0, 8'h00}};
    tbl[6] = '{8'h81, 8'h80, 24'h800000, 24'hFFFFFF, '{8'h81, 26'h2000000, 26'h1FFFFFE, 1'b0, 1'b0, 8'h01}};
    tbl[7] = '{8'h83, 8'h80, 24'h800000, 24'hFFFFFF, '{8'h83, 26'h2000000, 26'h07FFFFF, 1'b1, 1'b0, 8'h03}};
    tbl[8] = '{8'h9A, 8'h80, 24'h800000, 24'h800001, '{8'h9A, 26'h2000000, 26'h0000000, 1'b1, 1'b0, 8'h1A}};
    tbl[9] = '{8'h99, 8'h80, 24'h800000, 24'h800000, '{8'h99, 26'h2000000, 26'h0000001, 1'b0, 1'b0, 8'h19}};

    bus.in_valid  = 1'b0;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    bus.man_a     = '0;
    bus.man_b     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk_res("reset_data", actual(), zero_res);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1;

    // Table vectors, back-to-back
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // Backpressure: two accepted, third refused while stalled
    va = mk(8'h90, 8'h88, 24'hC0FFEE, 24'h8ABCDE);
    vb = mk(8'h20, 8'h2C, 24'hFEDCBA, 24'h812345);
    vc = mk(8'h77, 8'h77, 24'h800001, 24'hFFFF00);
    bus.out_ready = 1'b0;
    send(va);
    send(vb);
    bus.in_valid = 1'b1;
    bus.exp_a    = vc.ea;
    bus.exp_b    = vc.eb;
    bus.man_a    = vc.ma;
    bus.man_b    = vc.mb;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk_res("stall_hold", actual(), va.res);
      @(posedge CLK);
      #1;
    end
    bus.out_ready = 1'b1;
    send(vc);
    drain();

    // Streaming: 16 random pairs back-to-back, results on consecutive cycles
    stream_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ea, eb;
      ea = 8'($urandom_range(0, 255));
      if (i % 2 == 0) eb = 8'($urandom_range(0, 255));
      else eb = ea + 8'($urandom_range(0, 30));
      send(mk(ea, eb, 24'($urandom) | 24'h800000, 24'($urandom) | 24'h800000));
    end
    drain();
    stream_mode = 1'b0;
    chk("stream_count", 64'(stream_cnt), 64'd16);
    chk("stream_consecutive", 64'(stream_last - stream_first), 64'd15);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(mk(8'h55, 8'h50, 24'hFFFFFF, 24'hFFFFFF));
    send(mk(8'h40, 8'h60, 24'h123456, 24'h876543));
    RST = 1'b1;
    q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk_res("midreset_data", actual(), zero_res);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("no_stale_out_valid", 64'(bus.out_valid), 64'd0);

    // Latency after reset: out_valid rises on the second edge after acceptance
    send(mk(8'h84, 8'h81, 24'hF0000F, 24'h80000F));
    @(negedge CLK);
    chk("latency_edge1", 64'(bus.out_valid), 64'd0);
    @(negedge CLK);
    chk("latency_edge2", 64'(bus.out_valid), 64'd1);
    @(posedge CLK);
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
